power_manager: RTL and testbench

POWER_MANAGER -- requirements
Module: power_manager

---
 rtl/power_manager.sv | 265 ++++++++++++++++++++++++++
 tb/tb_power_manager.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_manager.sv
// power_manager: DVFS voltage/frequency stepping, per-domain idle power gating and a config regfile.
// Thermal throttling is compiled in when PM_THERMAL_THROTTLE_EN is defined.
module power_manager #(
  parameter int unsigned NUM_CORES          = 4,
  parameter int unsigned NUM_AI_UNITS       = 2,
  parameter int unsigned LOAD_MONITOR_WIDTH = 16,
  parameter int unsigned EVAL_PERIOD        = 16,
  parameter int unsigned IDLE_CYCLES        = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    dvfs_enable,
  input  logic [NUM_CORES*LOAD_MONITOR_WIDTH-1:0] core_load,
  input  logic [NUM_CORES-1:0]                    core_active,
  input  logic [NUM_CORES-1:0]                    core_activity,
  input  logic [LOAD_MONITOR_WIDTH-1:0]           memory_load,
  input  logic [LOAD_MONITOR_WIDTH-1:0]           noc_load,
  input  logic [LOAD_MONITOR_WIDTH-1:0]           ai_accel_load,
  input  logic                                    memory_activity,
  input  logic [NUM_AI_UNITS-1:0]                 ai_unit_activity,
  input  logic [15:0]                             temp_sensors [8],
  output logic [3:0]                              global_voltage,
  output logic [7:0]                              global_freq_div,
  output logic [NUM_CORES-1:0]                    core_power_enable,
  output logic [NUM_CORES-1:0]                    core_isolation_enable,
  output logic                                    l1_cache_power_enable,
  output logic                                    l2_cache_power_enable,
  output logic                                    memory_ctrl_power_enable,
  output logic                                    noc_power_enable,
  output logic                                    memory_isolation_enable,
  output logic [NUM_AI_UNITS-1:0]                 ai_unit_power_enable,
  output logic [NUM_AI_UNITS-1:0]                 ai_unit_isolation_enable,
  input  logic [31:0]                             pm_config_addr,
  input  logic [31:0]                             pm_config_wdata,
  input  logic                                    pm_config_req,
  input  logic                                    pm_config_we,
  output logic [31:0]                             pm_config_rdata,
  output logic                                    pm_config_ready
);

  localparam int unsigned W         = LOAD_MONITOR_WIDTH;
  localparam int unsigned CoreShift = $clog2(NUM_CORES);
  localparam int unsigned SumW      = W + CoreShift;
  localparam int unsigned EvalW     = (EVAL_PERIOD > 1) ? $clog2(EVAL_PERIOD) : 1;
  localparam int unsigned CntW      = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned NumDom    = NUM_CORES + NUM_AI_UNITS + 1;
  localparam int unsigned MemDom    = NumDom - 1;

  localparam logic [31:0] AddrCtrl = 32'h0000_0000;
  localparam logic [31:0] AddrMinV = 32'h0000_0004;
  localparam logic [31:0] AddrMaxV = 32'h0000_0008;
  localparam logic [31:0] AddrStat = 32'h0000_000C;

  typedef enum logic [1:0] {StOn, StIso, StOff, StWake} pd_state_e;

  logic             sw_en_q;
  logic [2:0]       min_volt_q, max_volt_q;
  logic             cfg_ready_q;
  logic [31:0]      cfg_rdata_q, rd_data;
  logic [2:0]       level_q;
  logic [EvalW-1:0] eval_cnt_q;
  logic             eval_tick;
  logic             dvfs_on;
  logic             alarm;
  logic [7:0]       freq_div;
  logic [SumW-1:0]  load_sum;
  logic [W-1:0]     core_avg, load_max;
  logic [3:0]       base_inc;
  logic [2:0]       base, target;
  logic [NumDom-1:0] dom_idle, dom_pwr, dom_iso;
  logic             unused_inputs;

  assign unused_inputs = ^{noc_load, pm_config_wdata[31:3]};

  assign dvfs_on  = dvfs_enable && sw_en_q;
  assign freq_div = {5'b0, 3'd7 - level_q};

  // Configuration register file
  always_comb begin
    rd_data = '0;
    case (pm_config_addr)
      AddrCtrl: rd_data = {31'b0, sw_en_q};
      AddrMinV: rd_data = {29'b0, min_volt_q};
      AddrMaxV: rd_data = {29'b0, max_volt_q};
      AddrStat: rd_data = {20'b0, alarm, level_q, freq_div};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_en_q     <= 1'b0;
      min_volt_q  <= 3'd1;
      max_volt_q  <= 3'd7;
      cfg_ready_q <= 1'b0;
      cfg_rdata_q <= '0;
    end else begin
      cfg_ready_q <= pm_config_req;
      if (pm_config_req && pm_config_we) begin
        case (pm_config_addr)
          AddrCtrl: sw_en_q    <= pm_config_wdata[0];
          AddrMinV: min_volt_q <= pm_config_wdata[2:0];
          AddrMaxV: max_volt_q <= pm_config_wdata[2:0];
          default:  ;
        endcase
      end
      if (pm_config_req && !pm_config_we) cfg_rdata_q <= rd_data;
    end
  end

  assign pm_config_ready = cfg_ready_q;
  assign pm_config_rdata = cfg_rdata_q;

  // Load estimate and target level
  always_comb begin
    load_sum = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      load_sum = load_sum + SumW'(core_load[i*W +: W]);
    end
  end

  assign core_avg = W'(load_sum >> CoreShift);

  always_comb begin
    load_max = core_avg;
    if (memory_load > load_max)   load_max = memory_load;
    if (ai_accel_load > load_max) load_max = ai_accel_load;
  end

  assign base_inc = {1'b0, load_max[W-1 -: 3]} + 4'd1;
  assign base     = base_inc[3] ? 3'd7 : base_inc[2:0];

  // Upper clamp applied last so MAX_VOLT wins when the limits cross
  always_comb begin
    target = base;
    if (target < min_volt_q) target = min_volt_q;
    if (target > max_volt_q) target = max_volt_q;
    if (!dvfs_on)            target = 3'd7;
    if (alarm && (target > 3'd1)) target = 3'd1;
  end

  assign eval_tick = (eval_cnt_q == EvalW'(EVAL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eval_cnt_q <= '0;
      level_q    <= 3'd7;
    end else begin
      eval_cnt_q <= eval_tick ? '0 : eval_cnt_q + EvalW'(1);
      if (eval_tick) begin
        if (level_q < target)      level_q <= level_q + 3'd1;
        else if (level_q > target) level_q <= level_q - 3'd1;
      end
    end
  end

  assign global_voltage  = {1'b0, level_q};
  assign global_freq_div = freq_div;

  // Thermal alarm with hysteresis
`ifdef PM_THERMAL_THROTTLE_EN
  logic alarm_q, any_hot, all_cool;

  always_comb begin
    any_hot  = 1'b0;
    all_cool = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (temp_sensors[i] >= 16'h5000) any_hot  = 1'b1;
      if (temp_sensors[i] >= 16'h4800) all_cool = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        alarm_q <= 1'b0;
    else if (any_hot)  alarm_q <= 1'b1;
    else if (all_cool) alarm_q <= 1'b0;
  end

  assign alarm = alarm_q;
`else
  logic unused_temp;

  always_comb begin
    unused_temp = 1'b0;
    for (int i = 0; i < 8; i++) unused_temp = unused_temp ^ (^temp_sensors[i]);
  end

  assign alarm = 1'b0;
`endif

  // Domain order: cores, AI units, memory controller
  always_comb begin
    dom_idle = '0;
    for (int i = 0; i < NUM_CORES; i++) dom_idle[i] = !core_active[i] || !core_activity[i];
    for (int j = 0; j < NUM_AI_UNITS; j++) dom_idle[NUM_CORES + j] = !ai_unit_activity[j];
    dom_idle[MemDom] = !memory_activity;
  end

  for (genvar g = 0; g < NumDom; g++) begin : g_dom
    pd_state_e       st_q;
    logic [CntW-1:0] cnt_q;
    logic            pwr_q, iso_q;
    logic            wake;

    assign wake = !dvfs_on || !dom_idle[g];

    // Isolation brackets the power-off window on both edges
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q  <= StOn;
        cnt_q <= '0;
        pwr_q <= 1'b1;
        iso_q <= 1'b0;
      end else begin
        unique case (st_q)
          StOn: begin
            if (wake) begin
              cnt_q <= '0;
            end else if (cnt_q == CntW'(IDLE_CYCLES - 1)) begin
              st_q  <= StIso;
              iso_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StIso: begin
            cnt_q <= '0;
            if (wake) begin
              st_q  <= StOn;
              iso_q <= 1'b0;
            end else begin
              st_q  <= StOff;
              pwr_q <= 1'b0;
            end
          end
          StOff: begin
            if (wake) begin
              st_q  <= StWake;
              pwr_q <= 1'b1;
            end
          end
          StWake: begin
            st_q  <= StOn;
            iso_q <= 1'b0;
          end
          default: st_q <= StOn;
        endcase
      end
    end

    assign dom_pwr[g] = pwr_q;
    assign dom_iso[g] = iso_q;
  end

  assign core_power_enable        = dom_pwr[NUM_CORES-1:0];
  assign core_isolation_enable    = dom_iso[NUM_CORES-1:0];
  assign ai_unit_power_enable     = dom_pwr[NUM_CORES +: NUM_AI_UNITS];
  assign ai_unit_isolation_enable = dom_iso[NUM_CORES +: NUM_AI_UNITS];
  assign memory_ctrl_power_enable = dom_pwr[MemDom];
  assign memory_isolation_enable  = dom_iso[MemDom];
  assign l2_cache_power_enable    = dom_pwr[MemDom];
  assign l1_cache_power_enable    = |dom_pwr[NUM_CORES-1:0];
  assign noc_power_enable         = 1'b1;

endmodule

// File: tb/tb_power_manager.sv
// Directed self-checking bench for power_manager (default parameters).
module tb_power_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dvfs_enable;
  logic [63:0] core_load;
  logic [3:0]  core_active, core_activity;
  logic [15:0] memory_load, noc_load, ai_accel_load;
  logic        memory_activity;
  logic [1:0]  ai_unit_activity;
  logic [15:0] temp_sensors [8];
  logic [3:0]  global_voltage;
  logic [7:0]  global_freq_div;
  logic [3:0]  core_power_enable, core_isolation_enable;
  logic        l1_cache_power_enable, l2_cache_power_enable, memory_ctrl_power_enable;
  logic        noc_power_enable, memory_isolation_enable;
  logic [1:0]  ai_unit_power_enable, ai_unit_isolation_enable;
  logic [31:0] pm_config_addr, pm_config_wdata, pm_config_rdata;
  logic        pm_config_req, pm_config_we, pm_config_ready;

  int checks = 0;
  int errors = 0;

  power_manager dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .dvfs_enable              (dvfs_enable),
    .core_load                (core_load),
    .core_active              (core_active),
    .core_activity            (core_activity),
    .memory_load              (memory_load),
    .noc_load                 (noc_load),
    .ai_accel_load            (ai_accel_load),
    .memory_activity          (memory_activity),
    .ai_unit_activity         (ai_unit_activity),
    .temp_sensors             (temp_sensors),
    .global_voltage           (global_voltage),
    .global_freq_div          (global_freq_div),
    .core_power_enable        (core_power_enable),
    .core_isolation_enable    (core_isolation_enable),
    .l1_cache_power_enable    (l1_cache_power_enable),
    .l2_cache_power_enable    (l2_cache_power_enable),
    .memory_ctrl_power_enable (memory_ctrl_power_enable),
    .noc_power_enable         (noc_power_enable),
    .memory_isolation_enable  (memory_isolation_enable),
    .ai_unit_power_enable     (ai_unit_power_enable),
    .ai_unit_isolation_enable (ai_unit_isolation_enable),
    .pm_config_addr           (pm_config_addr),
    .pm_config_wdata          (pm_config_wdata),
    .pm_config_req            (pm_config_req),
    .pm_config_we             (pm_config_we),
    .pm_config_rdata          (pm_config_rdata),
    .pm_config_ready          (pm_config_ready)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_loads(input logic [15:0] v);
    core_load     = {4{v}};
    memory_load   = v;
    noc_load      = v;
    ai_accel_load = v;
  endtask

  task automatic set_temps(input logic [15:0] v);
    for (int i = 0; i < 8; i++) temp_sensors[i] = v;
  endtask

  task automatic set_activity(input logic on);
    core_activity    = {4{on}};
    ai_unit_activity = {2{on}};
    memory_activity  = on;
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    pm_config_req   = 1'b1;
    pm_config_we    = 1'b1;
    pm_config_addr  = addr;
    pm_config_wdata = data;
    step(1);
    pm_config_req   = 1'b0;
    pm_config_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    pm_config_req  = 1'b1;
    pm_config_we   = 1'b0;
    pm_config_addr = addr;
    step(1);
    check({tag, "_ready"}, {31'b0, pm_config_ready}, 32'd1);
    check(tag, pm_config_rdata, exp);
    pm_config_req  = 1'b0;
    step(1);
    check({tag, "_ready_drop"}, {31'b0, pm_config_ready}, 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    dvfs_enable     = 1'b0;
    set_loads(16'h0000);
    set_temps(16'h0000);
    core_active     = 4'hF;
    set_activity(1'b1);
    pm_config_addr  = '0;
    pm_config_wdata = '0;
    pm_config_req   = 1'b0;
    pm_config_we    = 1'b0;
    step(3);

    // Reset state
    check("rst_voltage", {28'b0, global_voltage}, 32'd7);
    check("rst_freq", {24'b0, global_freq_div}, 32'd0);
    check("rst_core_pwr", {28'b0, core_power_enable}, 32'hF);
    check("rst_core_iso", {28'b0, core_isolation_enable}, 32'h0);
    check("rst_misc_pwr", {27'b0, l1_cache_power_enable, l2_cache_power_enable,
                           memory_ctrl_power_enable, ai_unit_power_enable}, 32'h1F);
    check("rst_ready_rdata", {pm_config_rdata[30:0], pm_config_ready}, 32'd0);
    rst_n = 1'b1;
    step(40);
    check("idle_dvfs_off_voltage", {28'b0, global_voltage}, 32'd7);
    check("idle_dvfs_off_pwr", {28'b0, core_power_enable}, 32'hF);

    // Register file
    cfg_read(32'h8, 32'd7, "rd_max_default");
    cfg_write(32'h4, 32'd2);
    cfg_read(32'h4, 32'd2, "rd_min_written");
    cfg_read(32'h10, 32'd0, "rd_unmapped");
    cfg_write(32'h4, 32'd1);
    cfg_write(32'h0, 32'd1);
    cfg_read(32'h0, 32'd1, "rd_ctrl");

    // Low load, all idle: exact gating sequence then low voltage
    set_loads(16'h1000);
    set_activity(1'b0);
    dvfs_enable = 1'b1;
    step(31);
    check("gate_iso_early", {28'b0, core_isolation_enable}, 32'h0);
    step(1);
    check("gate_iso_first", {27'b0, memory_isolation_enable, core_isolation_enable}, 32'h1F);
    check("gate_pwr_held", {28'b0, core_power_enable}, 32'hF);
    check("gate_ai_iso", {30'b0, ai_unit_isolation_enable}, 32'h3);
    step(1);
    check("gate_pwr_off", {28'b0, core_power_enable}, 32'h0);
    check("gate_caches", {29'b0, l1_cache_power_enable, l2_cache_power_enable,
                          noc_power_enable}, 32'h1);
    check("gate_ai_pwr", {30'b0, ai_unit_power_enable}, 32'h0);
    step(266);
    check("low_voltage", {28'b0, global_voltage}, 32'd1);
    check("low_freq", {24'b0, global_freq_div}, 32'd6);
    check("low_iso", {28'b0, core_isolation_enable}, 32'hF);
    cfg_read(32'hC, 32'h106, "rd_status_low");

    // High load, busy: power-up order then high voltage
    set_loads(16'hA000);
    set_activity(1'b1);
    step(1);
    check("wake_pwr_first", {28'b0, core_power_enable}, 32'hF);
    check("wake_iso_held", {28'b0, core_isolation_enable}, 32'hF);
    step(1);
    check("wake_iso_off", {27'b0, memory_isolation_enable, core_isolation_enable}, 32'h0);
    step(298);
    check("high_voltage", {28'b0, global_voltage}, 32'd6);
    check("high_freq", {24'b0, global_freq_div}, 32'd1);
    check("high_pwr", {28'b0, core_power_enable}, 32'hF);

    // Thermal throttle
    set_temps(16'h5500);
    step(200);
`ifdef PM_THERMAL_THROTTLE_EN
    check("hot_voltage", {28'b0, global_voltage}, 32'd1);
    check("hot_freq", {24'b0, global_freq_div}, 32'd6);
    cfg_read(32'hC, 32'h906, "rd_status_hot");
    set_temps(16'h1900);
    step(200);
    check("cool_voltage", {28'b0, global_voltage}, 32'd6);
`else
    check("hot_ignored_voltage", {28'b0, global_voltage}, 32'd6);
`endif
    cfg_read(32'hC, 32'h601, "rd_status_cool");
    set_temps(16'h0000);

    // Core average, and a disabled core gated while busy
    core_load     = {16'hC000, 16'h0000, 16'h0000, 16'h0000};
    memory_load   = 16'h0000;
    ai_accel_load = 16'h0000;
    core_active   = 4'b1101;
    step(200);
    check("avg_voltage", {28'b0, global_voltage}, 32'd2);
    check("inactive_core_pwr", {28'b0, core_power_enable}, 32'b1101);
    check("inactive_core_iso", {28'b0, core_isolation_enable}, 32'b0010);
    core_active = 4'hF;

    // Clamping window
    cfg_write(32'h4, 32'd3);
    cfg_write(32'h8, 32'd5);
    set_loads(16'hF000);
    step(200);
    check("clamp_max_voltage", {28'b0, global_voltage}, 32'd5);
    check("clamp_max_freq", {24'b0, global_freq_div}, 32'd2);
    set_loads(16'h0100);
    step(200);
    check("clamp_min_voltage", {28'b0, global_voltage}, 32'd3);
    cfg_write(32'h4, 32'd6);
    cfg_write(32'h8, 32'd4);
    set_loads(16'h0000);
    step(200);
    check("crossed_limits_voltage", {28'b0, global_voltage}, 32'd4);

    // Disabling DVFS restores all domains and full voltage
    set_activity(1'b0);
    step(100);
    check("pre_off_gated", {28'b0, core_power_enable}, 32'h0);
    dvfs_enable = 1'b0;
    step(1);
    check("off_pwr_first", {27'b0, memory_ctrl_power_enable, core_power_enable}, 32'h1F);
    check("off_iso_held", {28'b0, core_isolation_enable}, 32'hF);
    step(1);
    check("off_iso_clear", {26'b0, ai_unit_isolation_enable, core_isolation_enable}, 32'h0);
    step(200);
    check("off_voltage", {28'b0, global_voltage}, 32'd7);
    check("off_freq", {24'b0, global_freq_div}, 32'd0);
    check("off_stay_on", {28'b0, core_power_enable}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
